// File: rtl/cpu_pkg.sv
// Shared control-unit definitions: fetch FSM states, instruction field positions
// and bus widths used by the fetch unit and the decoder.
package cpu_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam int COND_MSB  = 31;
    localparam int COND_LSB  = 28;
    localparam int OP_MSB    = 27;
    localparam int OP_LSB    = 26;
    localparam int FUNCT_MSB = 25;
    localparam int FUNCT_LSB = 20;
    localparam int RD_MSB    = 15;
    localparam int RD_LSB    = 12;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of {instr, pc} pairs; registered head, no bypass.
// flush wins over push and pop in the same cycle.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [INSTR_W-1:0] push_instr,
    input  logic [ADDR_W-1:0]  push_pc,
    output logic [INSTR_W-1:0] head_instr,
    output logic [ADDR_W-1:0]  head_pc,
    output logic [PW:0]        count,
    output logic               full,
    output logic               empty
);

    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic [ADDR_W-1:0]  pc_mem    [DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic               do_pop;

    assign full       = (count == DEPTH_C);
    assign empty      = (count == '0);
    assign do_pop     = pop && !empty;
    assign head_instr = instr_mem[rd_ptr];
    assign head_pc    = pc_mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem[i] <= '0;
                pc_mem[i]    <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                instr_mem[wr_ptr] <= push_instr;
                pc_mem[wr_ptr]    <= push_pc;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: single-outstanding req/ack fetch into a prefetch queue,
// decode-side valid/ready presentation, and branch redirect with flush.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [INSTR_W-1:0] dec_instr,
    output logic [ADDR_W-1:0]  dec_pc,
    output logic [3:0]         dec_cond,
    output logic [1:0]         dec_op,
    output logic [5:0]         dec_funct,
    output logic [3:0]         dec_rd,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output fetch_state_t       dbg_state
);

    localparam int          PW      = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] target;
    logic [PW:0]       count, count_next;
    logic              full, empty;
    logic              push, pop, ack_in, done, issue_ok;

    // Handshakes: a transfer happens on a rising edge where valid (imem_req /
    // dec_valid) and its acceptor (imem_ack / dec_ready) are both high; the
    // producer holds valid and its payload stable until that edge.
    assign imem_req  = (state_q != IDLE);
    assign imem_addr = addr_q;
    assign dbg_state = state_q;
    assign target    = word_align(redirect_pc);

    assign ack_in    = imem_req && imem_ack;
    assign dec_valid = !empty && !redirect;
    assign pop       = dec_valid && dec_ready;
    assign push      = (state_q == BUSY) && imem_ack && !redirect && !full;

    // Occupancy after this edge; issuing only below DEPTH reserves a slot for the ack.
    assign count_next = redirect ? '0 : count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    assign issue_ok   = (count_next < DEPTH_C);
    assign done       = (state_q == IDLE) || ack_in;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;

        if (redirect) begin
            fetch_pc_d = target;
        end else if (push) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end

        if (done) begin
            if (issue_ok) begin
                state_d = BUSY;
                addr_d  = fetch_pc_d;
            end else begin
                state_d = IDLE;
            end
        end else if (redirect) begin
            state_d = DISCARD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
        end
    end

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pop        (pop),
        .flush      (redirect),
        .push_instr (imem_rdata),
        .push_pc    (imem_addr),
        .head_instr (dec_instr),
        .head_pc    (dec_pc),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

    assign dec_cond  = dec_instr[COND_MSB:COND_LSB];
    assign dec_op    = dec_instr[OP_MSB:OP_LSB];
    assign dec_funct = dec_instr[FUNCT_MSB:FUNCT_LSB];
    assign dec_rd    = dec_instr[RD_MSB:RD_LSB];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios, then a randomized run against
// a queue-based reference of the fetch/decode stream.
module tb_instr_fetch_unit;
    import cpu_pkg::*;

    localparam int          DEPTH   = 2;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    logic         clk = 1'b0;
    logic         rst;
    logic         imem_req, imem_ack;
    logic [31:0]  imem_addr, imem_rdata;
    logic         dec_valid, dec_ready;
    logic [31:0]  dec_instr, dec_pc;
    logic [3:0]   dec_cond, dec_rd;
    logic [1:0]   dec_op;
    logic [5:0]   dec_funct;
    logic         redirect;
    logic [31:0]  redirect_pc;
    fetch_state_t dbg_state;

    logic         w_req, w_ack, w_dec_valid, w_dec_ready, w_redirect;
    logic [31:0]  w_addr, w_rdata, w_dec_instr, w_dec_pc, w_redirect_pc;
    logic [3:0]   w_cond, w_rd;
    logic [1:0]   w_op;
    logic [5:0]   w_funct;
    fetch_state_t w_dbg_state;

    int           vectors = 0;
    int           miscompares = 0;
    logic [31:0]  salt = 32'h0;
    logic         mem_auto = 1'b1;
    int           max_delay = 0;
    int           cur_delay = 0;
    int           wait_cnt = 0;
    int           acks;

    logic [31:0]  exp_q[$];
    logic [31:0]  exp_fetch, exp_addr, exp_pc, exp_word;
    logic         exp_req, discard, ack_now, popped;

    always #5 clk = ~clk;

    instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr), .dec_pc(dec_pc),
        .dec_cond(dec_cond), .dec_op(dec_op), .dec_funct(dec_funct), .dec_rd(dec_rd),
        .redirect(redirect), .redirect_pc(redirect_pc), .dbg_state(dbg_state)
    );

    instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(WRAP_PC)) u_dut_wrap (
        .clk(clk), .rst(rst),
        .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack), .imem_rdata(w_rdata),
        .dec_valid(w_dec_valid), .dec_ready(w_dec_ready), .dec_instr(w_dec_instr), .dec_pc(w_dec_pc),
        .dec_cond(w_cond), .dec_op(w_op), .dec_funct(w_funct), .dec_rd(w_rd),
        .redirect(w_redirect), .redirect_pc(w_redirect_pc), .dbg_state(w_dbg_state)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hE000_0000 ^ salt;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: edge, settle, then the memory models answer the current request.
    task automatic tick();
        @(posedge clk);
        #1;
        w_ack   = w_req;
        w_rdata = w_addr ^ 32'hE000_0000;
        if (mem_auto) begin
            imem_ack   = imem_req && (wait_cnt >= cur_delay);
            imem_rdata = imem_ack ? mem_word(imem_addr) : 32'h0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        imem_ack = 1'b0;
        redirect = 1'b0;
        dec_ready = 1'b0;
        wait_cnt = 0;
        cur_delay = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        imem_ack = 1'b0; imem_rdata = 32'h0;
        dec_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        w_ack = 1'b0; w_rdata = 32'h0; w_dec_ready = 1'b1;
        w_redirect = 1'b0; w_redirect_pc = 32'h0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", 32'(dec_valid), 32'd0);
        check("rst_instr", dec_instr, 32'h0);
        check("rst_pc", dec_pc, 32'h0);
        check("rst_wrap_addr", w_addr, WRAP_PC);

        // Zero-wait streaming, plus RESET_PC wrap on the second instance
        mem_auto = 1'b1; dec_ready = 1'b1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stream_req", 32'(imem_req), 32'd1);
            check("stream_addr", imem_addr, 32'(4 * i));
            if (i < 3) check("wrap_addr", w_addr, WRAP_PC + 32'(4 * i));
            if (i > 0) begin
                check("stream_valid", 32'(dec_valid), 32'd1);
                check("stream_dec_pc", dec_pc, 32'(4 * (i - 1)));
                check("stream_cond", 32'(dec_cond), 32'hE);
            end
        end

        // Backpressure: queue fills after two acks, then resumes at 8
        do_reset();
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (imem_ack) acks++;
        end
        check("bp_acks", 32'(acks), 32'd2);
        check("bp_req_low", 32'(imem_req), 32'd0);
        dec_ready = 1'b1;
        #1;
        check("bp_head_valid", 32'(dec_valid), 32'd1);
        check("bp_head_pc", dec_pc, 32'h0);
        tick();
        check("bp_resume_req", 32'(imem_req), 32'd1);
        check("bp_resume_addr", imem_addr, 32'h8);
        check("bp_next_pc", dec_pc, 32'h4);

        // Redirect while a delayed request to 4 is outstanding
        do_reset();
        mem_auto = 1'b0; dec_ready = 1'b1;
        tick();
        check("rd_first_addr", imem_addr, 32'h0);
        imem_ack = 1'b1; imem_rdata = mem_word(32'h0);
        tick();
        check("rd_out_addr", imem_addr, 32'h4);
        imem_ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0103;
        #1;
        check("rd_masked_valid", 32'(dec_valid), 32'd0);
        tick();
        redirect = 1'b0;
        check("rd_hold_req", 32'(imem_req), 32'd1);
        check("rd_hold_addr1", imem_addr, 32'h4);
        check("rd_flushed", 32'(dec_valid), 32'd0);
        tick();
        check("rd_hold_addr2", imem_addr, 32'h4);
        imem_ack = 1'b1; imem_rdata = mem_word(32'h4);
        tick();
        check("rd_target_addr", imem_addr, 32'h100);
        check("rd_dropped", 32'(dec_valid), 32'd0);
        imem_ack = 1'b1; imem_rdata = mem_word(32'h100);
        tick();
        check("rd_first_valid", 32'(dec_valid), 32'd1);
        check("rd_first_pc", dec_pc, 32'h100);
        check("rd_first_instr", dec_instr, mem_word(32'h100));
        check("rd_next_addr", imem_addr, 32'h104);

        // Redirect and ack together with one queued entry
        imem_ack = 1'b1; imem_rdata = mem_word(32'h104);
        redirect = 1'b1; redirect_pc = 32'h0000_0200;
        #1;
        check("ra_valid_masked", 32'(dec_valid), 32'd0);
        tick();
        redirect = 1'b0; imem_ack = 1'b0;
        check("ra_empty", 32'(dec_valid), 32'd0);
        check("ra_req", 32'(imem_req), 32'd1);
        check("ra_addr", imem_addr, 32'h200);

        // Asynchronous reset in the middle of a request
        do_reset();
        mem_auto = 1'b0; dec_ready = 1'b0;
        tick();
        imem_ack = 1'b1; imem_rdata = mem_word(32'h0);
        tick();
        imem_ack = 1'b0;
        check("ar_pre_valid", 32'(dec_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("ar_req_drop", 32'(imem_req), 32'd0);
        check("ar_valid_drop", 32'(dec_valid), 32'd0);
        check("ar_addr", imem_addr, 32'h0);
        @(negedge clk);
        rst = 1'b0; mem_auto = 1'b1; wait_cnt = 0; cur_delay = 0; dec_ready = 1'b1;
        tick();
        check("ar_restart_req", 32'(imem_req), 32'd1);
        check("ar_restart_addr", imem_addr, 32'h0);

        // Randomized run against the reference stream model
        do_reset();
        salt = $urandom;
        max_delay = 3;
        cur_delay = $urandom_range(0, max_delay);
        wait_cnt = 0;
        exp_q.delete();
        exp_fetch = 32'h0; exp_req = 1'b1; exp_addr = 32'h0; discard = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            tick();
            check("rnd_req", 32'(imem_req), 32'(exp_req));
            if (exp_req) check("rnd_addr", imem_addr, exp_addr);
            dec_ready = ($urandom_range(0, 3) != 0);
            redirect  = ($urandom_range(0, 15) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                      : 32'($urandom_range(0, 4095));
            #1;
            check("rnd_valid", 32'(dec_valid), 32'((exp_q.size() > 0) && !redirect));
            ack_now = exp_req && imem_ack;
            popped  = (exp_q.size() > 0) && !redirect && dec_ready;
            if (popped) begin
                exp_pc   = exp_q.pop_front();
                exp_word = mem_word(exp_pc);
                check("rnd_dec_pc", dec_pc, exp_pc);
                check("rnd_dec_instr", dec_instr, exp_word);
                check("rnd_fields", {dec_cond, dec_op, dec_funct, dec_rd},
                      {exp_word[31:28], exp_word[27:26], exp_word[25:20], exp_word[15:12]});
            end
            if (redirect) begin
                exp_q.delete();
                exp_fetch = {redirect_pc[31:2], 2'b00};
            end else if (ack_now && !discard) begin
                exp_q.push_back(exp_addr);
                exp_fetch = exp_addr + 32'd4;
            end
            discard = exp_req && !ack_now && (discard || redirect);
            if (!(exp_req && !ack_now)) begin
                exp_req  = (exp_q.size() < DEPTH);
                exp_addr = exp_fetch;
            end
            if (ack_now) begin
                wait_cnt  = 0;
                cur_delay = $urandom_range(0, max_delay);
            end else if (imem_req) begin
                wait_cnt++;
            end
        end
        redirect = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction-supply end of the control unit interface: fetches 32-bit instructions from instruction memory over a req/ack handshake.
- Buffers fetched instructions in a small prefetch queue.
- Presents each instruction to decode as split Cond/Op/Funct/Rd fields with a valid/ready handshake.
- Consumes the branch decision (PCSrc and target) to flush the queue and redirect fetch.

Parameters:
- DEPTH, 2, prefetch queue entries; power of two, ≥2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request; held high until imem_ack.
- imem_addr  out  32  fetch address, word aligned; stable while imem_req=1.
- imem_ack  in  1  imem_rdata valid this cycle; completes the request.
- imem_rdata  in  32  fetched instruction word.
- dec_valid  out  1  queue head presented to decode.
- dec_ready  in  1  decode accepts the head this cycle.
- dec_instr  out  32  head instruction word.
- dec_pc  out  32  address of head instruction.
- dec_cond  out  4  dec_instr[31:28].
- dec_op  out  2  dec_instr[27:26].
- dec_funct  out  6  dec_instr[25:20].
- dec_rd  out  4  dec_instr[15:12].
- redirect  in  1  taken branch / PC write (PCSrc).
- redirect_pc  in  32  new fetch address; bits [1:0] ignored.

Behaviour:
- Reset (async, rst=1):
  - imem_req=0, imem_addr=RESET_PC, dec_valid=0, dec_instr/dec_pc=0.
  - fetch_pc=RESET_PC, queue empty, state IDLE.
  - Asserting rst mid-request abandons the request; memory must tolerate this.
- State machine (fetch_state_t):
  - IDLE (no outstanding request):
    - Issue when count_next < DEPTH: imem_req=1, imem_addr=fetch_pc → BUSY.
  - BUSY (request outstanding):
    - imem_req/imem_addr held until imem_ack.
    - On ack: push {imem_rdata, imem_addr}; fetch_pc += 4.
    - If space remains after the push: assign next address and keep req=1, staying BUSY (back-to-back, 1 instr/cycle with zero-wait memory).
    - Otherwise req=0 → IDLE.
  - DISCARD (request outstanding, flushed by a redirect):
    - Holds req/addr until imem_ack.
    - Drops the returned data (no push) and does not increment fetch_pc.
    - Then issues fetch_pc in the next cycle → BUSY.
- Issue rule: outstanding + count ≤ DEPTH at all times; never more than one outstanding request.
- Redirect (sampled at the edge):
  - Queue flushed; fetch_pc = {redirect_pc[31:2], 2'b00}.
  - BUSY without ack → DISCARD.
  - BUSY with ack the same cycle → data dropped, next cycle issues the redirect target.
  - IDLE → next cycle imem_req=1 with the target.
  - Latency: redirect at edge N → new address on imem_addr in cycle N+1 when nothing is outstanding.
  - Redirect in DISCARD: only fetch_pc is updated.
- Decode handshake:
  - dec_valid = queue non-empty AND NOT redirect (combinational mask).
  - Pop when dec_valid && dec_ready.
  - A pop masked by redirect does not happen; the entry is flushed.
- Timing:
  - Push and pop in the same cycle keep count unchanged.
  - Data acked at cycle M appears on decode no earlier than M+1 (registered queue, no bypass).
- Outputs:
  - dec_* fields are pure slices of the queue head.
  - When the queue is empty they hold the last value and are don't-care.
- Arithmetic: fetch_pc + 4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- Queue boundaries:
  - Full: no new issue; an outstanding ack is always accepted (space reserved by the issue rule).
  - Empty with dec_ready=1: no pop, dec_valid=0.

Decomposition:
- cpu_pkg holds:
  - fetch_state_t {IDLE, BUSY, DISCARD}.
  - Field position constants (COND_MSB/LSB, OP_MSB/LSB, FUNCT_MSB/LSB, RD_MSB/LSB), shared with the control unit decoder.
  - INSTR_W=32, ADDR_W=32.
- Sub-module fetch_queue:
  - Synchronous FIFO of {instr, pc}, DEPTH entries.
  - Ports: push, pop, flush, count, full, empty.
  - flush has priority over push and pop.

Test Plan:
- Reset then zero-wait memory (ack same cycle as req, rdata=addr^32'hE000_0000), dec_ready=1 → imem_addr sequence 0,4,8,C on consecutive cycles; dec_pc 0,4,8 one cycle after each ack; dec_cond=4'hE.
- dec_ready=0, DEPTH=2 → exactly 2 acks accepted, then imem_req=0; raise dec_ready → req resumes at address 8.
- Redirect to 32'h0000_0103 while a request to 4 is outstanding with ack delayed 3 cycles:
  - imem_addr holds 4 until ack; returned word is dropped.
  - Next request at 32'h0000_0100; first dec_pc after redirect is 0x100.
- Redirect and imem_ack in the same cycle, queue holding 1 entry, dec_ready=1 → dec_valid=0 that cycle; queue empty next cycle; next imem_addr is the target.
- RESET_PC=32'hFFFF_FFF8, zero-wait memory → addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
- rst asserted mid-BUSY → imem_req and dec_valid drop immediately (asynchronously); after release, fetch restarts at RESET_PC.
